logic_result_checker: RTL and testbench

Synthesizable response checker for the ALU bitwise stage: it is the consuming end of the operand/result stream that stimulus logic drives into the logic gates. It accepts (op, A, B, Y) vectors over a valid/ready handshake and recomputes the expected result with an internal reference model. It counts vectors and mismatches, captures the first failing vector, and flags pass/done when a programmed number of vectors has retired. It sits beside the bitwise unit and provides on-chip self-check without a simulator.

---
 rtl/logic_chk_pkg.sv | 22 ++
 rtl/logic_ref_model.sv | 28 ++
 rtl/logic_result_checker.sv | 142 ++++++++++++++
 tb/tb_logic_result_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_chk_pkg.sv
// Shared definitions for the logic-stage response checkers: opcodes, FSM states
// and the width of the run counters.
package logic_chk_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/logic_ref_model.sv
// Combinational golden model of the bitwise stage: the expected result of
// (op, a, b), kept separate so other checkers can reuse it.
module logic_ref_model
  import logic_chk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
    endcase
  end

endmodule

// File: rtl/logic_result_checker.sv
// On-chip response checker for the bitwise stage: counts vectors and mismatches
// per run. First-failure capture is built only when FAIL_CAPTURE_EN is defined.
module logic_result_checker
  import logic_chk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic [7:0]       vec_cnt,
  output logic [7:0]       err_cnt,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_op,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_y,
  output logic [7:0]       fail_idx,
  output logic             fail_valid
);

  localparam logic [CNT_W-1:0] NUM_V = CNT_W'(NUM_VECTORS);

  state_t           state, state_next;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, s1_y;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             mismatch;
  logic             retire_last;

  logic_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (expected)
  );

  assign accept      = in_valid && in_ready;
  assign mismatch    = s1_valid && (expected != s1_y);
  assign retire_last = s1_valid && (vec_cnt == NUM_V - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (start)            state_next = ST_RUN;
        else if (retire_last) state_next = ST_DONE;
      end
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // in_ready depends only on state and acc_cnt so the producer never sees a loop
  always_comb begin
    in_ready = (state == ST_RUN) && (acc_cnt < NUM_V);
    done     = (state == ST_DONE);
    pass     = (state == ST_DONE) && (err_cnt == '0);
  end

  // start has priority: it clears the run and drops any vector still in stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      vec_cnt  <= '0;
      err_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_y     <= '0;
    end else if (start) begin
      acc_cnt  <= '0;
      vec_cnt  <= '0;
      err_cnt  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
        s1_op   <= op;
        s1_a    <= a;
        s1_b    <= b;
        s1_y    <= y;
      end
      if (s1_valid) vec_cnt <= vec_cnt + CNT_W'(1);
      if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifdef FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_op    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_y     <= '0;
      fail_idx   <= '0;
    end else if (start) begin
      fail_valid <= 1'b0;
      fail_op    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_y     <= '0;
      fail_idx   <= '0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_op    <= s1_op;
      fail_a     <= s1_a;
      fail_b     <= s1_b;
      fail_y     <= s1_y;
      fail_idx   <= vec_cnt;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_op    = '0;
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_y     = '0;
  assign fail_idx   = '0;
`endif

endmodule

// File: tb/tb_logic_result_checker.sv
// Self-checking bench for logic_result_checker: directed runs from the test plan
// plus randomized runs, all compared every cycle against a queue-based model.
module tb_logic_result_checker;

  localparam int W = 4;
  localparam int N = 8;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, y = '0;
  logic [7:0]   vec_cnt, err_cnt, fail_idx;
  logic         done, pass, fail_valid;
  logic [2:0]   fail_op;
  logic [W-1:0] fail_a, fail_b, fail_y;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state
  int         m_acc, m_vec, m_err, m_idx;
  bit         m_run, m_done, m_fv;
  vec_t       m_fail;
  vec_t       pend[$];

  logic_result_checker #(.WIDTH(W), .NUM_VECTORS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .y          (y),
    .vec_cnt    (vec_cnt),
    .err_cnt    (err_cnt),
    .done       (done),
    .pass       (pass),
    .fail_op    (fail_op),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_y     (fail_y),
    .fail_idx   (fail_idx),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  // Truth table per op, indexed by {a_bit, b_bit}
  function automatic logic [W-1:0] ref_val(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] z);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b1001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic model_clear();
    m_acc = 0; m_vec = 0; m_err = 0; m_idx = 0; m_fv = 0; m_fail = '0;
    pend.delete();
  endtask

  initial begin
    vec_t v;
    bit   can_acc;
    model_clear();
    m_run = 0; m_done = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear(); m_run = 0; m_done = 0;
      end else if (start) begin
        model_clear(); m_run = 1; m_done = 0;
      end else begin
        can_acc = m_run && (m_acc < N);
        while (pend.size() > 0) begin
          v = pend.pop_front();
          if (ref_val(v.op, v.a, v.b) != v.y) begin
            if (m_err < 255) m_err++;
`ifdef FAIL_CAPTURE_EN
            if (!m_fv) begin m_fv = 1; m_fail = v; m_idx = m_vec; end
`endif
          end
          m_vec++;
          if (m_vec == N) begin m_run = 0; m_done = 1; end
        end
        if (can_acc && in_valid) begin
          pend.push_back('{op: op, a: a, b: b, y: y});
          m_acc++;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("in_ready",   32'(in_ready),   32'(m_run && (m_acc < N)));
      check_output("vec_cnt",    32'(vec_cnt),    32'(m_vec));
      check_output("err_cnt",    32'(err_cnt),    32'(m_err));
      check_output("done",       32'(done),       32'(m_done));
      check_output("pass",       32'(pass),       32'(m_done && m_err == 0));
      check_output("fail_valid", 32'(fail_valid), 32'(m_fv));
      check_output("fail_op",    32'(fail_op),    32'(m_fail.op));
      check_output("fail_a",     32'(fail_a),     32'(m_fail.a));
      check_output("fail_b",     32'(fail_b),     32'(m_fail.b));
      check_output("fail_y",     32'(fail_y),     32'(m_fail.y));
      check_output("fail_idx",   32'(fail_idx),   32'(m_idx));
    end
  end

  // All tasks begin and end 1ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [2:0] o, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic [W-1:0] yv, input int gaps);
    bit rdy;
    int tries;
    step(gaps);
    op = o; a = av; b = bv; y = yv; in_valid = 1'b1;
    tries = 0;
    rdy = 1'b0;
    while (!rdy && tries < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!rdy) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept after %0d cycles, required accept", tries);
    end
    in_valid = 1'b0;
  endtask

  task automatic random_vector(input int gap_max, input int err_pct);
    logic [2:0]   o;
    logic [W-1:0] av, bv, yv;
    o  = 3'($urandom_range(7));
    av = W'($urandom);
    bv = W'($urandom);
    yv = ref_val(o, av, bv);
    if ($urandom_range(99) < err_pct) yv = yv ^ W'($urandom_range(15, 1));
    apply_stimulus(o, av, bv, yv, $urandom_range(gap_max));
  endtask

  logic [W-1:0] xa[8] = '{4'b0000, 4'b0000, 4'b1010, 4'b1100, 4'b1111, 4'b0110, 4'b1001, 4'b1101};
  logic [W-1:0] xb[8] = '{4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b1111, 4'b0110, 4'b1001, 4'b0111};
  logic [W-1:0] xy[8] = '{4'b1111, 4'b0000, 4'b0000, 4'b1001, 4'b1111, 4'b1111, 4'b1111, 4'b0101};
  logic [W-1:0] opy[8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0001, 4'b0011, 4'b1100};

  initial begin
    logic [W-1:0] yv;
    // reset state
    step(3);
    check_output("rst_in_ready",   32'(in_ready),   32'd0);
    check_output("rst_vec_cnt",    32'(vec_cnt),    32'd0);
    check_output("rst_err_cnt",    32'(err_cnt),    32'd0);
    check_output("rst_done",       32'(done),       32'd0);
    check_output("rst_pass",       32'(pass),       32'd0);
    check_output("rst_fail_valid", 32'(fail_valid), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step(2);

    $display("[TB] clean XNOR run");
    pulse_start();
    for (int i = 0; i < 8; i++) apply_stimulus(3'd3, xa[i], xb[i], xy[i], 0);
    step(2);
    check_output("xnor_vec_cnt", 32'(vec_cnt), 32'd8);
    check_output("xnor_err_cnt", 32'(err_cnt), 32'd0);
    check_output("xnor_done",    32'(done),    32'd1);
    check_output("xnor_pass",    32'(pass),    32'd1);
    check_output("xnor_fail_valid", 32'(fail_valid), 32'd0);

    $display("[TB] fault injection run");
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      yv = xy[i];
      if (i == 3) yv = 4'b1111;
      if (i == 6) yv = 4'b0000;
      apply_stimulus(3'd3, xa[i], xb[i], yv, 0);
    end
    step(2);
    check_output("fault_err_cnt", 32'(err_cnt), 32'd2);
    check_output("fault_pass",    32'(pass),    32'd0);
    check_output("fault_done",    32'(done),    32'd1);
`ifdef FAIL_CAPTURE_EN
    check_output("fault_fail_valid", 32'(fail_valid), 32'd1);
    check_output("fault_fail_idx",   32'(fail_idx),   32'd3);
    check_output("fault_fail_a",     32'(fail_a),     32'hC);
    check_output("fault_fail_b",     32'(fail_b),     32'hA);
    check_output("fault_fail_y",     32'(fail_y),     32'hF);
    check_output("fault_fail_op",    32'(fail_op),    32'd3);
`endif

    $display("[TB] backpressure and overflow vector");
    pulse_start();
    for (int i = 0; i < 8; i++) random_vector(3, 20);
    check_output("bp_in_ready_after_last", 32'(in_ready), 32'd0);
    check_output("bp_done_not_yet",        32'(done),     32'd0);
    step(1);
    check_output("bp_done_next_cycle",     32'(done),     32'd1);
    check_output("bp_vec_cnt",             32'(vec_cnt),  32'd8);
    op = 3'd0; a = 4'b1111; b = 4'b1111; y = 4'b0000; in_valid = 1'b1;
    step(4);
    in_valid = 1'b0;
    check_output("bp_ninth_in_ready", 32'(in_ready), 32'd0);
    check_output("bp_ninth_vec_cnt",  32'(vec_cnt),  32'd8);

    $display("[TB] restart then all-opcode run");
    pulse_start();
    for (int i = 0; i < 5; i++)
      apply_stimulus(3'd0, 4'b1100, 4'b1010, (i == 2) ? 4'b0000 : 4'b1000, 0);
    pulse_start();
    check_output("restart_vec_cnt",    32'(vec_cnt),    32'd0);
    check_output("restart_err_cnt",    32'(err_cnt),    32'd0);
    check_output("restart_fail_valid", 32'(fail_valid), 32'd0);
    for (int i = 0; i < 8; i++) apply_stimulus(3'(i), 4'b1100, 4'b1010, opy[i], 0);
    step(2);
    check_output("allop_err_cnt", 32'(err_cnt), 32'd0);
    check_output("allop_pass",    32'(pass),    32'd1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      if (r == 2) begin
        for (int i = 0; i < 3; i++) random_vector(2, 30);
        pulse_start();
      end
      for (int i = 0; i < 8; i++) random_vector(2, 25);
      step(3);
    end

    $display("[TB] async reset mid-run");
    pulse_start();
    for (int i = 0; i < 3; i++) apply_stimulus(3'd2, 4'b1100, 4'b1010, 4'b0110, 0);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_in_ready", 32'(in_ready), 32'd0);
    check_output("arst_vec_cnt",  32'(vec_cnt),  32'd0);
    check_output("arst_err_cnt",  32'(err_cnt),  32'd0);
    check_output("arst_done",     32'(done),     32'd0);
    step(2);
    rst_n = 1'b1;
    op = 3'd2; a = 4'b1100; b = 4'b1010; y = 4'b0110; in_valid = 1'b1;
    step(3);
    in_valid = 1'b0;
    check_output("arst_idle_vec_cnt", 32'(vec_cnt), 32'd0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
